// File: rtl/uart_pkg.sv
// Shared types and frame-timing helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_HOLD
    } arb_state_t;

    // System clock cycles per UART bit; clk_fre is given in MHz.
    function automatic int bit_cycles(input int clk_fre, input int baud);
        return (clk_fre * 1_000_000) / baud;
    endfunction

    // Start + data + optional parity + stop.
    function automatic int frame_bits(input int dw, input int parity);
        return 2 + dw + parity;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr,
// otherwise wraps to the lowest requester overall.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [N-1:0] upper;
    logic [N-1:0] pool;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign upper[gi] = req[gi] && (IW'(gi) >= ptr);
    end

    assign pool = (|upper) ? upper : req;
    assign any  = |req;

    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pool[k]) begin
                idx = IW'(k);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant[gi] = any && (idx == IW'(gi));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte requesters, spacing frames by counting
// out a full frame plus guard bits. Define UART_ARB_PRIO_EN to give requester 0 priority.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ON  = 1,
    parameter int NUM_REQ    = 4,
    parameter int GAP_BITS   = 1
) (
    input  logic                           i_clk_sys,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [DATA_WIDTH-1:0]          o_data_tx,
    output logic                           o_data_valid,
    output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
    output logic                           o_busy
);

    localparam int IDX_W       = $clog2(NUM_REQ);
    localparam int BIT_CYCLES  = bit_cycles(CLK_FRE, BAUD_RATE);
    localparam int FRAME_BITS  = frame_bits(DATA_WIDTH, PARITY_ON);
    localparam int HOLD_CYCLES = (FRAME_BITS + GAP_BITS) * BIT_CYCLES;
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1);

    arb_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       ptr_reg, ptr_next;
    logic [IDX_W-1:0]       grant_id_reg, grant_id_next;
    logic [DATA_WIDTH-1:0]  data_reg, data_next;

    logic [NUM_REQ-1:0]     pick_req;
    logic [NUM_REQ-1:0]     rr_grant;
    logic [NUM_REQ-1:0]     grant_vec;
    logic [IDX_W-1:0]       rr_idx;
    logic [IDX_W-1:0]       grant_idx;
    logic                   rr_any;
    logic                   prio_hit;
    logic                   grant_any;
    logic                   accept;

`ifdef UART_ARB_PRIO_EN
    // Requester 0 bypasses the rotation; the others rotate among themselves.
    assign prio_hit = i_req_valid[0];
    assign pick_req = {i_req_valid[NUM_REQ-1:1], 1'b0};
`else
    assign prio_hit = 1'b0;
    assign pick_req = i_req_valid;
`endif

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req   (pick_req),
        .ptr   (ptr_reg),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    assign grant_any = prio_hit | rr_any;
    assign grant_idx = prio_hit ? '0 : rr_idx;
    assign grant_vec = prio_hit ? NUM_REQ'(1) : rr_grant;
    // Reset masks the accept so no requester is consumed while reset is held.
    assign accept    = (state_reg == ARB_IDLE) && grant_any && !i_rst;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ptr_next      = ptr_reg;
        grant_id_next = grant_id_reg;
        data_next     = data_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (accept) begin
                    state_next    = ARB_ISSUE;
                    data_next     = i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_next = grant_idx;
                    if (!prio_hit) begin
                        ptr_next = (rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rr_idx + IDX_W'(1);
                    end
                end
            end
            ARB_ISSUE: begin
                state_next = ARB_HOLD;
                cnt_next   = CNT_W'(HOLD_CYCLES - 1);
            end
            ARB_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = ARB_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_reg    <= ARB_IDLE;
            cnt_reg      <= '0;
            ptr_reg      <= '0;
            grant_id_reg <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ptr_reg      <= ptr_next;
            grant_id_reg <= grant_id_next;
            data_reg     <= data_next;
        end
    end

    assign o_req_ready  = accept ? grant_vec : '0;
    assign o_data_tx    = data_reg;
    assign o_data_valid = (state_reg == ARB_ISSUE);
    assign o_grant_id   = grant_id_reg;
    assign o_busy       = (state_reg != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random requesters,
// all checked cycle by cycle against a timeline model of the arbiter.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int IW      = 2;
    localparam int HOLD    = (2 + DW + 1 + 1) * (1 * 1000000 / 100000);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ*DW-1:0]  req_data = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [DW-1:0]          data_tx;
    logic                   data_valid;
    logic [IW-1:0]          grant_id;
    logic                   busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .CLK_FRE    (1),
        .BAUD_RATE  (100000),
        .DATA_WIDTH (DW),
        .PARITY_ON  (1),
        .NUM_REQ    (NUM_REQ),
        .GAP_BITS   (1)
    ) dut (
        .i_clk_sys    (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .o_data_tx    (data_tx),
        .o_data_valid (data_valid),
        .o_grant_id   (grant_id),
        .o_busy       (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mode = 0;   // 0 drop on ready, 1 keep valid with new byte, 2 random, 3 keep same byte
    bit checks_on = 0;

    // Model: arbiter as a timeline of accept / pulse / busy windows.
    int m_ptr = 0;
    int m_earliest = 0;
    int m_dv_at = -1;
    int m_busy_until = -1;
    int m_gid = 0;
    logic [DW-1:0] m_data = '0;
    int acc_cyc = -1;

    int prev_dv = -1;
    int last_dv_cyc = -1;
    logic [DW-1:0] last_dv_data = '0;
    int last_rdy_cyc = -1;
    int grants[$];
    int dv_times[$];
    logic [DW-1:0] dv_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int first_from(input int p, input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic tick();
        int g;
        bit acc;
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] masked;
        logic [NUM_REQ-1:0] nv;
        logic [NUM_REQ*DW-1:0] nd;
        @(negedge clk);
        acc = 0;
        g = 0;
        if (!rst && cyc >= m_earliest && req_valid != '0) begin
            acc = 1;
            masked = req_valid;
`ifdef UART_ARB_PRIO_EN
            masked[0] = 1'b0;
            if (req_valid[0]) g = 0;
            else g = first_from(m_ptr, masked);
`else
            g = first_from(m_ptr, masked);
`endif
        end
        exp_ready = acc ? (NUM_REQ'(1) << g) : '0;
        if (checks_on) begin
            check("ready", 32'(req_ready), 32'(exp_ready));
            check("data_valid", 32'(data_valid), 32'(cyc == m_dv_at));
            check("data_tx", 32'(data_tx), 32'(m_data));
            check("grant_id", 32'(grant_id), 32'(m_gid));
            check("busy", 32'(busy), 32'(cyc <= m_busy_until));
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'(1));
        end
        if (data_valid === 1'b1) begin
            if (prev_dv >= 0) check("dv_spacing", 32'((cyc - prev_dv) >= HOLD + 2), 32'(1));
            prev_dv = cyc;
            last_dv_cyc = cyc;
            last_dv_data = data_tx;
            dv_times.push_back(cyc);
            dv_data.push_back(data_tx);
            $display("cycle %0d: issue byte 0x%02h from requester %0d", cyc, data_tx, grant_id);
        end
        if (req_ready != '0) begin
            last_rdy_cyc = cyc;
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_ready[k] === 1'b1) g = k;
            end
            grants.push_back(g);
        end
        if (rst) begin
            m_ptr = 0; m_earliest = cyc + 1; m_dv_at = -1; m_busy_until = -1;
            m_gid = 0; m_data = '0; prev_dv = -1;
        end else if (acc) begin
            m_dv_at = cyc + 1;
            m_busy_until = cyc + 1 + HOLD;
            m_earliest = cyc + 2 + HOLD;
            m_data = req_data[g*DW +: DW];
            m_gid = g;
            acc_cyc = cyc;
`ifdef UART_ARB_PRIO_EN
            if (g != 0) m_ptr = (g + 1) % NUM_REQ;
`else
            m_ptr = (g + 1) % NUM_REQ;
`endif
        end
        nv = req_valid;
        nd = req_data;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (req_ready[n] === 1'b1) begin
                if (mode == 1) nd[n*DW +: DW] = 8'($urandom);
                else if (mode != 3) nv[n] = 1'b0;
            end else if (mode == 2) begin
                if (!nv[n]) begin
                    if ($urandom_range(0, 99) < 3) begin
                        nv[n] = 1'b1;
                        nd[n*DW +: DW] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 999) < 2) begin
                    nv[n] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = nv;
        req_data = nd;
        cyc++;
        checks_on = 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle();
        while (cyc < m_earliest) tick();
    endtask

    initial begin
        int t;
        int exp3[5];
        int exp6[4];
        logic [DW-1:0] expd3[5];
`ifdef UART_ARB_PRIO_EN
        exp3 = '{0, 0, 0, 0, 0};
        expd3 = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
        exp6 = '{0, 0, 0, 0};
`else
        exp3 = '{0, 1, 2, 3, 0};
        expd3 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        exp6 = '{0, 2, 0, 2};
`endif

        // Single request at cycle 10.
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(7);
        req_valid[1] = 1'b1;
        req_data[1*DW +: DW] = 8'hA5;
        run(1);
        check("s1_accept_cycle", 32'(last_rdy_cyc), 32'(10));
        run(1);
        check("s1_pulse_cycle", 32'(last_dv_cyc), 32'(11));
        check("s1_pulse_data", 32'(last_dv_data), 32'hA5);
        run(121);
        check("s1_idle_at_132", 32'(busy), 32'(0));

        // Back-to-back single requester.
        mode = 1;
        dv_times.delete();
        req_valid[0] = 1'b1;
        req_data[0 +: DW] = 8'($urandom);
        run(3 * 122 + 5);
        check("s2_pulse_count", 32'(dv_times.size()), 32'(4));
        for (int k = 1; k < dv_times.size(); k++) begin
            check("s2_pulse_gap", 32'(dv_times[k] - dv_times[k-1]), 32'(122));
        end
        req_valid = '0;
        mode = 0;
        wait_idle();

        // Rotation with all four requesters valid from reset.
        rst = 1'b1;
        mode = 3;
        req_valid = 4'hF;
        req_data = 32'h13121110;
        run(1);
        rst = 1'b0;
        grants.delete();
        dv_data.delete();
        run(500);
        for (int k = 0; k < 5; k++) begin
            check("s3_grant", 32'(k < grants.size() ? grants[k] : -1), 32'(exp3[k]));
            check("s3_data", 32'(k < dv_data.size() ? int'(dv_data[k]) : -1), 32'(expd3[k]));
        end
        req_valid = '0;
        mode = 0;
        wait_idle();

        // Request arriving during HOLD waits for the window to close.
        req_valid[0] = 1'b1;
        req_data[0 +: DW] = 8'($urandom);
        run(1);
        t = acc_cyc;
        run(49);
        req_valid[2] = 1'b1;
        req_data[2*DW +: DW] = 8'h5C;
        run(72);
        check("s4_no_early_ready", 32'(last_rdy_cyc), 32'(t));
        run(1);
        check("s4_ready_cycle", 32'(last_rdy_cyc), 32'(t + 122));
        check("s4_grant", 32'(grants[$]), 32'(2));
        run(1);
        check("s4_pulse_cycle", 32'(last_dv_cyc), 32'(t + 123));
        check("s4_pulse_data", 32'(last_dv_data), 32'h5C);
        wait_idle();

        // Reset mid-frame with requester 3 pending.
        req_valid[1] = 1'b1;
        req_data[1*DW +: DW] = 8'h3C;
        run(1);
        t = acc_cyc;
        run(9);
        req_valid[3] = 1'b1;
        req_data[3*DW +: DW] = 8'h77;
        run(30);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(1);
        check("s5_accept_after_reset", 32'(last_rdy_cyc), 32'(t + 42));
        check("s5_grant", 32'(grants[$]), 32'(3));
        run(1);
        check("s5_pulse_data", 32'(last_dv_data), 32'h77);
        wait_idle();

        // Requesters 0 and 2 continuously valid.
        rst = 1'b1;
        mode = 3;
        req_valid = 4'b0101;
        req_data = 32'h00C200C0;
        run(1);
        rst = 1'b0;
        grants.delete();
        run(4 * 122);
        for (int k = 0; k < 4; k++) begin
            check("s6_grant", 32'(k < grants.size() ? grants[k] : -1), 32'(exp6[k]));
        end
        req_valid = '0;
        mode = 0;
        wait_idle();

        // Random requesters with occasional resets.
        mode = 2;
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 999) < 3);
            tick();
        end
        rst = 1'b0;
        mode = 0;
        req_valid = '0;
        wait_idle();
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
